// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline.
// Word/register widths, ALU op and funct encodings, multiplier states.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RLEN = 5;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_SLTI  = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_t;

    function automatic logic add_ovf(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [XLEN-1:0] s
    );
        return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
    endfunction

    function automatic logic sub_ovf(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [XLEN-1:0] d
    );
        return (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
    endfunction

endpackage

// File: rtl/ex_stage_multu.sv
// 32-iteration shift-add unsigned multiplier.
// product is the accumulator after the current iteration; valid when done.
module multu_seq
    import mips_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic              active,
    output logic [2*XLEN-1:0] product
);

    mul_state_t        state;
    logic [4:0]        count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign active   = (state == ST_MUL);
    assign done     = active && (count == 5'd31);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                state  <= ST_MUL;
                count  <= '0;
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, a};
                mplier <= b;
            end
        end else if (abort) begin
            state <= ST_IDLE;
        end else if (!hold) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (count == 5'd31) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution, HI/LO with sequential multu,
// and the EX/MEM boundary registers.
module ex_stage
    import mips_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            branch,
    input  logic            jump,
    input  logic            AluSrc,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            RegDst,
    input  logic            MemtoReg,
    input  logic [1:0]      AluOp,
    input  logic [XLEN-1:0] npc,
    input  logic [XLEN-1:0] readdata1,
    input  logic [XLEN-1:0] readdata2,
    input  logic [XLEN-1:0] sigext,
    input  logic [RLEN-1:0] instruction_2015,
    input  logic [RLEN-1:0] instruction_1511,
    input  logic            flush,
    input  logic            hold,
    output logic            busy,
    output logic            branch_taken_out,
    output logic [XLEN-1:0] branch_target_out,
    output logic            jump_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic            RegWrite_out,
    output logic            MemtoReg_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic            zero_out,
    output logic [XLEN-1:0] writedata_out,
    output logic [RLEN-1:0] writereg_out,
    output logic            overflow_out
);

    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   sum;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ovf;
    logic              bad_funct;
    logic              is_multu;
    logic              bubble;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              mul_start;
    logic              mul_done;
    logic              mul_active;
    logic [2*XLEN-1:0] product;

    assign funct = sigext[5:0];
    assign shamt = sigext[10:6];
    assign op_b  = AluSrc ? sigext : readdata2;
    assign sum   = readdata1 + op_b;
    assign diff  = readdata1 - op_b;

    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        bad_funct = 1'b0;
        unique case (AluOp)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf(readdata1, op_b, sum);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf(readdata1, op_b, diff);
            end
            ALU_SLTI: begin
                alu_res = {31'd0, $signed(readdata1) < $signed(op_b)};
            end
            ALU_RTYPE: begin
                unique case (funct)
                    F_ADD: begin
                        alu_res = sum;
                        alu_ovf = add_ovf(readdata1, op_b, sum);
                    end
                    F_SUB: begin
                        alu_res = diff;
                        alu_ovf = sub_ovf(readdata1, op_b, diff);
                    end
                    F_ADDU:  alu_res = sum;
                    F_SUBU:  alu_res = diff;
                    F_AND:   alu_res = readdata1 & op_b;
                    F_OR:    alu_res = readdata1 | op_b;
                    F_XOR:   alu_res = readdata1 ^ op_b;
                    F_NOR:   alu_res = ~(readdata1 | op_b);
                    F_SLT: begin
                        alu_res = {31'd0, $signed(readdata1) < $signed(op_b)};
                    end
                    F_SLTU:  alu_res = {31'd0, readdata1 < op_b};
                    F_SLL:   alu_res = readdata2 << shamt;
                    F_SRL:   alu_res = readdata2 >> shamt;
                    F_SRA:   alu_res = $unsigned($signed(readdata2) >>> shamt);
                    F_MFHI:  alu_res = hi;
                    F_MFLO:  alu_res = lo;
                    F_MULTU: alu_res = '0;
                    default: bad_funct = 1'b1;
                endcase
            end
        endcase
    end

    assign is_multu  = (AluOp == ALU_RTYPE) && (funct == F_MULTU);
    assign bubble    = mul_active || is_multu;
    assign mul_start = !mul_active && is_multu && !flush && !hold;
    assign busy      = (!mul_active && is_multu && !flush)
                     || (mul_active && !mul_done);

    multu_seq u_multu (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush),
        .hold    (hold),
        .a       (readdata1),
        .b       (readdata2),
        .done    (mul_done),
        .active  (mul_active),
        .product (product)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done && !flush && !hold) begin
            hi <= product[2*XLEN-1:XLEN];
            lo <= product[XLEN-1:0];
        end
    end

    // Flush beats hold; in-flight multiply cycles always drain as bubbles.
    always_ff @(posedge clock) begin
        if (reset || flush || (!hold && bubble)) begin
            branch_taken_out  <= 1'b0;
            branch_target_out <= '0;
            jump_out          <= 1'b0;
            MemRead_out       <= 1'b0;
            MemWrite_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            MemtoReg_out      <= 1'b0;
            alu_result_out    <= '0;
            zero_out          <= 1'b0;
            writedata_out     <= '0;
            writereg_out      <= '0;
            overflow_out      <= 1'b0;
        end else if (!hold) begin
            branch_taken_out  <= branch && (alu_res == '0);
            branch_target_out <= npc + {sigext[XLEN-3:0], 2'b00};
            jump_out          <= jump;
            MemRead_out       <= MemRead;
            MemWrite_out      <= MemWrite;
            RegWrite_out      <= RegWrite && !alu_ovf && !bad_funct;
            MemtoReg_out      <= MemtoReg;
            alu_result_out    <= alu_res;
            zero_out          <= (alu_res == '0);
            writedata_out     <= readdata2;
            writereg_out      <= RegDst ? instruction_1511 : instruction_2015;
            overflow_out      <= alu_ovf;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a behavioural model.
module tb_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        branch, jump, AluSrc, MemRead, MemWrite;
    logic        RegWrite, RegDst, MemtoReg;
    logic [1:0]  AluOp;
    logic [31:0] npc, readdata1, readdata2, sigext;
    logic [4:0]  instruction_2015, instruction_1511;
    logic        flush, hold;
    logic        busy;
    logic        branch_taken_out;
    logic [31:0] branch_target_out;
    logic        jump_out, MemRead_out, MemWrite_out;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] alu_result_out;
    logic        zero_out;
    logic [31:0] writedata_out;
    logic [4:0]  writereg_out;
    logic        overflow_out;

    typedef struct packed {
        logic        bt;
        logic [31:0] tgt;
        logic        j;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic [31:0] res;
        logic        z;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        ov;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    exp_t  cur;

    ex_stage dut (
        .clock             (clock),
        .reset             (reset),
        .branch            (branch),
        .jump              (jump),
        .AluSrc            (AluSrc),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .RegWrite          (RegWrite),
        .RegDst            (RegDst),
        .MemtoReg          (MemtoReg),
        .AluOp             (AluOp),
        .npc               (npc),
        .readdata1         (readdata1),
        .readdata2         (readdata2),
        .sigext            (sigext),
        .instruction_2015  (instruction_2015),
        .instruction_1511  (instruction_1511),
        .flush             (flush),
        .hold              (hold),
        .busy              (busy),
        .branch_taken_out  (branch_taken_out),
        .branch_target_out (branch_target_out),
        .jump_out          (jump_out),
        .MemRead_out       (MemRead_out),
        .MemWrite_out      (MemWrite_out),
        .RegWrite_out      (RegWrite_out),
        .MemtoReg_out      (MemtoReg_out),
        .alu_result_out    (alu_result_out),
        .zero_out          (zero_out),
        .writedata_out     (writedata_out),
        .writereg_out      (writereg_out),
        .overflow_out      (overflow_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t dut_out();
        return exp_t'({branch_taken_out, branch_target_out, jump_out,
                       MemRead_out, MemWrite_out, RegWrite_out,
                       MemtoReg_out, alu_result_out, zero_out,
                       writedata_out, writereg_out, overflow_out});
    endfunction

    // Reference: what the MEM stage should see for the presented instruction.
    function automatic exp_t model();
        exp_t        e;
        logic [31:0] b;
        logic [31:0] r;
        longint      s;
        longint      sa;
        longint      sb;
        bit          ov;
        bit          ill;
        e  = '0;
        r  = 32'd0;
        ov = 0;
        ill = 0;
        b  = AluSrc ? sigext : readdata2;
        sa = $signed(readdata1);
        sb = $signed(b);
        case (AluOp)
            2'd0: begin
                s = sa + sb; r = s[31:0];
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd1: begin
                s = sa - sb; r = s[31:0];
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                case (sigext[5:0])
                    6'h20: begin
                        s = sa + sb; r = s[31:0];
                        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    6'h22: begin
                        s = sa - sb; r = s[31:0];
                        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    end
                    6'h21: r = readdata1 + b;
                    6'h23: r = readdata1 - b;
                    6'h24: r = readdata1 & b;
                    6'h25: r = readdata1 | b;
                    6'h26: r = readdata1 ^ b;
                    6'h27: r = ~(readdata1 | b);
                    6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: r = (readdata1 < b) ? 32'd1 : 32'd0;
                    6'h00: r = readdata2 << sigext[10:6];
                    6'h02: r = readdata2 >> sigext[10:6];
                    6'h03: r = $unsigned($signed(readdata2) >>> sigext[10:6]);
                    6'h10: r = m_hi;
                    6'h12: r = m_lo;
                    default: ill = 1;
                endcase
            end
        endcase
        e.res = r;
        e.ov  = ov;
        e.rw  = RegWrite && !ov && !ill;
        e.z   = (r == 32'd0);
        e.bt  = branch && e.z;
        e.tgt = npc + sigext * 32'd4;
        e.j   = jump;
        e.mr  = MemRead;
        e.mw  = MemWrite;
        e.m2r = MemtoReg;
        e.wd  = readdata2;
        e.wr  = RegDst ? instruction_1511 : instruction_2015;
        return e;
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom % 16)
            0: return 6'h20;
            1: return 6'h21;
            2: return 6'h22;
            3: return 6'h23;
            4: return 6'h24;
            5: return 6'h25;
            6: return 6'h26;
            7: return 6'h27;
            8: return 6'h2A;
            9: return 6'h2B;
            10: return 6'h00;
            11: return 6'h02;
            12: return 6'h03;
            13: return 6'h10;
            14: return 6'h12;
            default: return 6'h3F;
        endcase
    endfunction

    task automatic idle_inputs();
        {branch, jump, AluSrc, MemRead, MemWrite} = '0;
        {RegWrite, RegDst, MemtoReg} = '0;
        AluOp = 2'd0;
        npc = 0; readdata1 = 0; readdata2 = 0; sigext = 0;
        instruction_2015 = 0; instruction_1511 = 0;
        flush = 0; hold = 0;
    endtask

    task automatic set_rtype(input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b);
        idle_inputs();
        AluOp = 2'b10; RegWrite = 1; RegDst = 1;
        sigext = {26'd0, f};
        readdata1 = a; readdata2 = b;
        npc = $urandom;
        instruction_2015 = 5'($urandom);
        instruction_1511 = 5'($urandom);
    endtask

    task automatic rand_instr();
        {branch, jump, AluSrc, MemRead, MemWrite} = 5'($urandom);
        {RegWrite, RegDst, MemtoReg} = 3'($urandom);
        AluOp = 2'($urandom);
        npc = $urandom;
        readdata1 = ($urandom % 4 == 0) ? 32'h7FFFFFF0 + ($urandom % 32)
                                         : $urandom;
        readdata2 = $urandom;
        sigext = $urandom;
        sigext[5:0] = pick_funct();
        instruction_2015 = 5'($urandom);
        instruction_1511 = 5'($urandom);
    endtask

    task automatic test_reset();
        exp_t got;
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        m_hi = 0; m_lo = 0;
        got = dut_out();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        cur = '0;
    endtask

    task automatic test_overflow();
        exp_t e;
        set_rtype(6'h20, 32'h7FFFFFFF, 32'd1);
        e = model();
        step();
        checks++;
        if (overflow_out !== 1 || RegWrite_out !== 0
            || alu_result_out !== 32'h80000000) begin
            errors++;
            $display("FAIL add_ovf got ov=%b rw=%b res=%h exp 1 0 80000000",
                     overflow_out, RegWrite_out, alu_result_out);
        end
        checks++;
        if (dut_out() !== e) begin
            errors++;
            $display("FAIL add_ovf_all got %h exp %h", dut_out(), e);
        end
        set_rtype(6'h21, 32'h7FFFFFFF, 32'd1);
        step();
        checks++;
        if (overflow_out !== 0 || RegWrite_out !== 1
            || alu_result_out !== 32'h80000000) begin
            errors++;
            $display("FAIL addu got ov=%b rw=%b res=%h exp 0 1 80000000",
                     overflow_out, RegWrite_out, alu_result_out);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        branch = 1; AluOp = 2'b01;
        readdata1 = 5; readdata2 = 5;
        npc = 32'h100; sigext = 32'hFFFFFFFF;
        step();
        checks++;
        if (branch_taken_out !== 1 || branch_target_out !== 32'h000000FC
            || zero_out !== 1) begin
            errors++;
            $display("FAIL branch got bt=%b tgt=%h z=%b exp 1 000000fc 1",
                     branch_taken_out, branch_target_out, zero_out);
        end
    endtask

    task automatic test_random_alu();
        exp_t e;
        for (int i = 0; i < 80; i++) begin
            rand_instr();
            flush = ($urandom % 8 == 0);
            hold  = (i > 0) && ($urandom % 8 == 0);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_busy[%0d] got %b exp 0", i, busy);
            end
            if (flush) e = '0;
            else if (hold) e = cur;
            else e = model();
            step();
            checks++;
            if (dut_out() !== e) begin
                errors++;
                $display("FAIL rand_alu[%0d] op=%0d f=%h got %h exp %h",
                         i, AluOp, sigext[5:0], dut_out(), e);
            end
            cur = e;
        end
        idle_inputs();
    endtask

    task automatic test_hold_add();
        exp_t e;
        set_rtype(6'h20, $urandom % 1000, $urandom % 1000);
        e = model();
        step();
        cur = e;
        for (int i = 0; i < 3; i++) begin
            set_rtype(6'h26, $urandom, $urandom);
            hold = 1;
            step();
            checks++;
            if (dut_out() !== cur) begin
                errors++;
                $display("FAIL hold_add[%0d] got %h exp %h", i, dut_out(), cur);
            end
        end
        hold = 0;
        e = model();
        step();
        checks++;
        if (dut_out() !== e) begin
            errors++;
            $display("FAIL hold_release got %h exp %h", dut_out(), e);
        end
    endtask

    task automatic test_flush_hold();
        set_rtype(6'h21, 32'd1, 32'd2);
        MemWrite = 1; jump = 1;
        flush = 1; hold = 1;
        step();
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("FAIL flush_hold got %h exp 0", dut_out());
        end
        idle_inputs();
        cur = '0;
    endtask

    task automatic read_hilo(input string tag);
        exp_t e;
        set_rtype(6'h10, $urandom, $urandom);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_mfhi_busy got %b exp 0", tag, busy);
        end
        e = model();
        step();
        checks++;
        if (dut_out() !== e || alu_result_out !== m_hi) begin
            errors++;
            $display("FAIL %s_mfhi got %h exp %h", tag, alu_result_out, m_hi);
        end
        set_rtype(6'h12, $urandom, $urandom);
        e = model();
        step();
        checks++;
        if (dut_out() !== e || alu_result_out !== m_lo) begin
            errors++;
            $display("FAIL %s_mflo got %h exp %h", tag, alu_result_out, m_lo);
        end
    endtask

    task automatic run_multu(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input int hcyc);
        int  n;
        bit  done;
        logic [63:0] p;
        set_rtype(6'h19, a, b);
        jump = 1; MemWrite = 1; branch = 1;
        #1;
        n = busy ? 1 : 0;
        done = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            hold = (hcyc >= 0) && (cyc >= hcyc) && (cyc < hcyc + 3);
            step();
            checks++;
            if (dut_out() !== '0) begin
                errors++;
                $display("FAIL %s_bubble[%0d] got %h exp 0", tag, cyc, dut_out());
            end
            if (busy) n++;
            else done = 1;
        end
        hold = 0;
        checks++;
        if (!done || n != 32 + ((hcyc >= 0) ? 3 : 0)) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d exp %0d", tag, n,
                     32 + ((hcyc >= 0) ? 3 : 0));
        end
        step();
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("FAIL %s_last_bubble got %h exp 0", tag, dut_out());
        end
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
        read_hilo(tag);
    endtask

    task automatic test_multu_max();
        run_multu("mulmax", 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        checks++;
        if (m_hi !== 32'hFFFFFFFE || m_lo !== 32'h00000001) begin
            errors++;
            $display("FAIL mulmax_const got %h_%h exp fffffffe_00000001",
                     m_hi, m_lo);
        end
    endtask

    task automatic test_multu_flush();
        exp_t e;
        set_rtype(6'h19, 32'd3, 32'd4);
        for (int i = 0; i <= 10; i++) step();
        flush = 1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before got %b exp 1", busy);
        end
        step();
        set_rtype(6'h12, $urandom, $urandom);
        #1;
        checks++;
        if (busy !== 1'b0 || dut_out() !== '0) begin
            errors++;
            $display("FAIL flush_abort busy=%b got %h exp 0", busy, dut_out());
        end
        e = model();
        step();
        checks++;
        if (dut_out() !== e || alu_result_out !== m_lo) begin
            errors++;
            $display("FAIL flush_old_lo got %h exp %h", alu_result_out, m_lo);
        end
    endtask

    task automatic test_multu_hold();
        run_multu("mulhold", $urandom, $urandom, 5);
        run_multu("mulrand", $urandom, $urandom, -1);
    endtask

    task automatic test_reset_in_mul();
        set_rtype(6'h19, 32'd7, 32'd9);
        for (int i = 0; i < 6; i++) step();
        reset = 1;
        step();
        reset = 0;
        m_hi = 0; m_lo = 0;
        set_rtype(6'h10, 32'd1, 32'd1);
        #1;
        checks++;
        if (busy !== 1'b0 || dut_out() !== '0) begin
            errors++;
            $display("FAIL reset_mul busy=%b got %h exp 0", busy, dut_out());
        end
        read_hilo("rstmul");
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_overflow();
        test_branch();
        test_random_alu();
        test_hold_add();
        test_flush_hold();
        test_multu_max();
        test_multu_flush();
        test_multu_hold();
        test_reset_in_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
